// File: rtl/bcd_edit_ctrl_if.sv
// Edit-register bus between the screen FSM / RTC side and the BCD edit controller.
// slave is the controller's view, master is the driver's view.
interface bcd_edit_ctrl_if;
  logic [1:0] FSMedit;
  logic [1:0] FSMpos;
  logic       sw_formato;
  logic       btn_up;
  logic       btn_down;
  logic [7:0] rtc_f3;
  logic [7:0] rtc_f2;
  logic [7:0] rtc_f1;
  logic [7:0] num3;
  logic [7:0] num2;
  logic [7:0] num1;
  logic       edit_active;
  logic       commit;
  logic [1:0] commit_mode;

  modport slave (
    input  FSMedit, FSMpos, sw_formato, btn_up, btn_down, rtc_f3, rtc_f2, rtc_f1,
    output num3, num2, num1, edit_active, commit, commit_mode
  );

  modport master (
    output FSMedit, FSMpos, sw_formato, btn_up, btn_down, rtc_f3, rtc_f2, rtc_f1,
    input  num3, num2, num1, edit_active, commit, commit_mode
  );
endinterface

// File: rtl/bcd_edit_ctrl.sv
// Packed-BCD edit registers for time/date/timer editing: load from RTC on entry,
// step the selected field with up/down edges, pulse commit on exit.
module bcd_edit_ctrl (
  input  logic           clk,
  input  logic           reset,
  bcd_edit_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT} state_t;

  localparam logic [1:0] M_FECHA = 2'd2;
  localparam logic [1:0] M_HORA  = 2'd3;

  // fld numbering follows the register names: 3 = num3, 2 = num2, 1 = num1
  function automatic logic is_h12(input logic [1:0] mode, input logic [1:0] fld, input logic fmt);
    return (mode == M_HORA) && (fld == 2'd3) && fmt;
  endfunction

  function automatic logic [7:0] fmin(input logic [1:0] mode, input logic [1:0] fld, input logic fmt);
    logic [7:0] r;
    r = 8'h00;
    if (is_h12(mode, fld, fmt))             r = 8'h01;
    if (mode == M_FECHA && fld != 2'd1)     r = 8'h01;
    return r;
  endfunction

  function automatic logic [7:0] fmax(input logic [1:0] mode, input logic [1:0] fld, input logic fmt);
    logic [7:0] r;
    case (fld)
      2'd3:    r = (mode == M_FECHA) ? 8'h31 : (is_h12(mode, fld, fmt) ? 8'h12 : 8'h23);
      2'd2:    r = (mode == M_FECHA) ? 8'h12 : 8'h59;
      default: r = (mode == M_FECHA) ? 8'h99 : 8'h59;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    return (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] b);
    return (b[3:0] == 4'd0) ? {b[7:4] - 4'd1, 4'd9} : {b[7:4], b[3:0] - 4'd1};
  endfunction

  // Out-of-range or non-BCD collapses to the field minimum; 12 h PM bit rides along untouched.
  function automatic logic [7:0] fsan(input logic [7:0] v, input logic [1:0] mode,
                                      input logic [1:0] fld, input logic fmt);
    logic       h12;
    logic [7:0] b, lo, hi;
    h12 = is_h12(mode, fld, fmt);
    b   = h12 ? {1'b0, v[6:0]} : v;
    lo  = fmin(mode, fld, fmt);
    hi  = fmax(mode, fld, fmt);
    if (b[7:4] > 4'd9 || b[3:0] > 4'd9 || b < lo || b > hi) b = lo;
    return {b[7] | (h12 & v[7]), b[6:0]};
  endfunction

  function automatic logic [7:0] fstep(input logic [7:0] v, input logic [1:0] mode,
                                       input logic [1:0] fld, input logic fmt, input logic up);
    logic       h12, pm;
    logic [7:0] s, b, lo, hi;
    h12 = is_h12(mode, fld, fmt);
    s   = fsan(v, mode, fld, fmt);
    pm  = h12 & s[7];
    b   = h12 ? {1'b0, s[6:0]} : s;
    lo  = fmin(mode, fld, fmt);
    hi  = fmax(mode, fld, fmt);
    if (up) begin
      if (h12 && b == 8'h11) pm = ~pm;
      b = (b == hi) ? lo : bcd_inc(b);
    end else begin
      if (h12 && b == 8'h12) pm = ~pm;
      b = (b == lo) ? hi : bcd_dec(b);
    end
    return {b[7] | pm, b[6:0]};
  endfunction

  state_t     state_q;
  logic [1:0] mode_q;
  logic [7:0] num3_q, num2_q, num1_q;
  logic       edit_active_q, commit_q;
  logic [1:0] commit_mode_q;
  logic       up_q, dn_q;

  logic       up_edge, dn_edge, step_en;
  logic [1:0] sel_fld;
  logic [7:0] cur_val, step_d;

  assign up_edge = bus.btn_up & ~up_q;
  assign dn_edge = bus.btn_down & ~dn_q;

  always_comb begin
    sel_fld = 2'd0;
    case (bus.FSMpos)
      2'd1:    sel_fld = 2'd3;
      2'd2:    sel_fld = 2'd2;
      2'd3:    sel_fld = 2'd1;
      default: sel_fld = 2'd0;
    endcase
  end

  always_comb begin
    cur_val = num1_q;
    case (sel_fld)
      2'd3:    cur_val = num3_q;
      2'd2:    cur_val = num2_q;
      default: cur_val = num1_q;
    endcase
  end

  assign step_en = (up_edge ^ dn_edge) && (sel_fld != 2'd0);
  assign step_d  = fstep(cur_val, mode_q, sel_fld, bus.sw_formato, up_edge);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      mode_q        <= 2'd0;
      num3_q        <= 8'h00;
      num2_q        <= 8'h00;
      num1_q        <= 8'h00;
      edit_active_q <= 1'b0;
      commit_q      <= 1'b0;
      commit_mode_q <= 2'd0;
      up_q          <= 1'b0;
      dn_q          <= 1'b0;
    end else begin
      // edge history advances every cycle so edges outside EDIT are dropped, not queued
      up_q <= bus.btn_up;
      dn_q <= bus.btn_down;
      case (state_q)
        S_IDLE: begin
          if (bus.FSMedit != 2'd0) begin
            mode_q  <= bus.FSMedit;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          num3_q        <= fsan(bus.rtc_f3, mode_q, 2'd3, bus.sw_formato);
          num2_q        <= fsan(bus.rtc_f2, mode_q, 2'd2, bus.sw_formato);
          num1_q        <= fsan(bus.rtc_f1, mode_q, 2'd1, bus.sw_formato);
          edit_active_q <= 1'b1;
          state_q       <= S_EDIT;
        end
        S_EDIT: begin
          if (bus.FSMedit != mode_q) begin
            edit_active_q <= 1'b0;
            commit_q      <= 1'b1;
            commit_mode_q <= mode_q;
            state_q       <= S_COMMIT;
          end else if (step_en) begin
            case (sel_fld)
              2'd3:    num3_q <= step_d;
              2'd2:    num2_q <= step_d;
              default: num1_q <= step_d;
            endcase
          end
        end
        default: begin
          commit_q <= 1'b0;
          if (bus.FSMedit != 2'd0) begin
            mode_q  <= bus.FSMedit;
            state_q <= S_LOAD;
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.num3        = num3_q;
  assign bus.num2        = num2_q;
  assign bus.num1        = num1_q;
  assign bus.edit_active = edit_active_q;
  assign bus.commit      = commit_q;
  assign bus.commit_mode = commit_mode_q;
endmodule

// File: tb/tb_bcd_edit_ctrl.sv
// Directed bench for bcd_edit_ctrl: expectations queued at stimulus time,
// popped and asserted once the DUT output for that step is visible.
module tb_bcd_edit_ctrl;
  logic clk;
  logic reset;
  bcd_edit_ctrl_if bus ();

  bcd_edit_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [7:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [7:0] fld_val(input logic [1:0] pos);
    case (pos)
      2'd1:    return bus.num3;
      2'd2:    return bus.num2;
      default: return bus.num1;
    endcase
  endfunction

  // One clean button press on the currently selected field, then release.
  task automatic press(input logic up, input string tag, input logic [7:0] exp);
    expect_v(tag, exp);
    if (up) bus.btn_up = 1'b1;
    else    bus.btn_down = 1'b1;
    tick();
    chk(fld_val(bus.FSMpos));
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.FSMedit    = 2'd0;
    bus.FSMpos     = 2'd0;
    bus.sw_formato = 1'b0;
    bus.btn_up     = 1'b0;
    bus.btn_down   = 1'b0;
    bus.rtc_f3     = 8'h00;
    bus.rtc_f2     = 8'h00;
    bus.rtc_f1     = 8'h00;
    tick();
    tick();

    expect_v("rst_num3", 8'h00);        chk(bus.num3);
    expect_v("rst_num2", 8'h00);        chk(bus.num2);
    expect_v("rst_num1", 8'h00);        chk(bus.num1);
    expect_v("rst_edit_active", 8'h00); chk({7'd0, bus.edit_active});
    expect_v("rst_commit", 8'h00);      chk({7'd0, bus.commit});
    expect_v("rst_commit_mode", 8'h00); chk({6'd0, bus.commit_mode});
    reset = 1'b0;
    tick();

    // hora 24 h
    bus.rtc_f3 = 8'h23; bus.rtc_f2 = 8'h59; bus.rtc_f1 = 8'h07;
    bus.FSMpos = 2'd1;  bus.FSMedit = 2'd3;
    tick();
    expect_v("load_cycle_edit_active", 8'h00); chk({7'd0, bus.edit_active});
    tick();
    expect_v("h24_edit_active", 8'h01); chk({7'd0, bus.edit_active});
    expect_v("h24_load_num3", 8'h23);   chk(bus.num3);
    expect_v("h24_load_num2", 8'h59);   chk(bus.num2);
    expect_v("h24_load_num1", 8'h07);   chk(bus.num1);
    press(1'b1, "h24_num3_wrap_up", 8'h00);
    bus.FSMpos = 2'd2;
    press(1'b1, "h24_num2_wrap_up", 8'h00);
    expect_v("h24_num3_untouched", 8'h00); chk(bus.num3);
    bus.FSMpos = 2'd0;
    bus.btn_up = 1'b1; tick(); bus.btn_up = 1'b0; tick();
    expect_v("pos0_no_step_num1", 8'h07); chk(bus.num1);

    bus.FSMpos = 2'd3;
    expect_v("held_up_one_step", 8'h08);
    bus.btn_up = 1'b1;
    for (int i = 0; i < 100; i++) tick();
    chk(bus.num1);
    bus.btn_up = 1'b0;
    tick();
    expect_v("both_edges_ignored", 8'h08);
    bus.btn_up = 1'b1; bus.btn_down = 1'b1;
    tick();
    chk(bus.num1);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    tick();

    bus.FSMedit = 2'd0;
    tick();
    expect_v("exit_commit", 8'h01);       chk({7'd0, bus.commit});
    expect_v("exit_commit_mode", 8'h03);  chk({6'd0, bus.commit_mode});
    expect_v("exit_edit_active", 8'h00);  chk({7'd0, bus.edit_active});
    expect_v("exit_num1_held", 8'h08);    chk(bus.num1);
    tick();
    expect_v("commit_one_cycle", 8'h00);  chk({7'd0, bus.commit});
    expect_v("idle_num1_held", 8'h08);    chk(bus.num1);
    expect_v("idle_mode_held", 8'h03);    chk({6'd0, bus.commit_mode});

    // hora 12 h, PM toggling around 11/12
    bus.sw_formato = 1'b1;
    bus.rtc_f3 = 8'h11; bus.rtc_f2 = 8'h30; bus.rtc_f1 = 8'h45;
    bus.FSMpos = 2'd1;  bus.FSMedit = 2'd3;
    tick(); tick();
    expect_v("h12_load", 8'h11); chk(bus.num3);
    press(1'b1, "h12_11_to_12pm", 8'h92);
    press(1'b1, "h12_12_to_01",   8'h81);
    press(1'b0, "h12_01_to_12",   8'h92);
    press(1'b0, "h12_12_to_11am", 8'h11);
    bus.FSMedit = 2'd0;
    tick(); tick();
    bus.sw_formato = 1'b0;

    // timer load sanitising, then direct switch to fecha
    bus.rtc_f3 = 8'h15; bus.rtc_f2 = 8'h7A; bus.rtc_f1 = 8'h30;
    bus.FSMedit = 2'd1;
    tick(); tick();
    expect_v("timer_san_num2", 8'h00); chk(bus.num2);
    expect_v("timer_num3", 8'h15);     chk(bus.num3);
    bus.rtc_f3 = 8'h00; bus.rtc_f2 = 8'h12; bus.rtc_f1 = 8'h09;
    bus.FSMedit = 2'd2;
    tick();
    expect_v("switch_commit", 8'h01);      chk({7'd0, bus.commit});
    expect_v("switch_commit_mode", 8'h01); chk({6'd0, bus.commit_mode});
    expect_v("switch_num1_held", 8'h30);   chk(bus.num1);
    tick();
    expect_v("switch_commit_drop", 8'h00); chk({7'd0, bus.commit});
    tick();
    expect_v("fecha_san_num3", 8'h01); chk(bus.num3);
    expect_v("fecha_num2", 8'h12);     chk(bus.num2);
    expect_v("fecha_num1", 8'h09);     chk(bus.num1);
    bus.FSMpos = 2'd1;
    press(1'b0, "fecha_day_wrap_down", 8'h31);
    bus.FSMpos = 2'd2;
    press(1'b1, "fecha_month_wrap_up", 8'h01);
    bus.FSMpos = 2'd3;
    press(1'b1, "fecha_year_carry", 8'h10);
    bus.FSMedit = 2'd0;
    tick();
    expect_v("fecha_commit_mode", 8'h02); chk({6'd0, bus.commit_mode});
    tick();

    // reset while editing aborts without commit
    bus.rtc_f3 = 8'h23; bus.rtc_f2 = 8'h59; bus.rtc_f1 = 8'h07;
    bus.FSMedit = 2'd3;
    tick(); tick();
    expect_v("pre_reset_num3", 8'h23); chk(bus.num3);
    reset = 1'b1;
    tick();
    expect_v("midrst_num3", 8'h00);        chk(bus.num3);
    expect_v("midrst_num2", 8'h00);        chk(bus.num2);
    expect_v("midrst_num1", 8'h00);        chk(bus.num1);
    expect_v("midrst_edit_active", 8'h00); chk({7'd0, bus.edit_active});
    expect_v("midrst_commit_mode", 8'h00); chk({6'd0, bus.commit_mode});
    bus.FSMedit = 2'd0;
    reset = 1'b0;
    tick();
    expect_v("midrst_no_commit", 8'h00);   chk({7'd0, bus.commit});
    tick();
    expect_v("midrst_no_commit_2", 8'h00); chk({7'd0, bus.commit});

    if (sb_q.size() != 0) begin
      errors++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
